runway_scheduler: RTL and testbench

RUNWAY_SCHEDULER -- requirements
Module: runway_scheduler

---
 rtl/runway_scheduler.sv | 134 +++++++++++++
 tb/tb_runway_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/runway_scheduler.sv
// -----------------------------------------------------------------------------
// runway_scheduler
//
// Queues aircraft landing requests and assigns each one to runway A or B,
// holding each runway occupied for OCC_CYCLES clocks. When both runways are
// busy, one "wait" command is issued per queue head. A registered command
// code/en pair drives the downstream runway status stage.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   req_valid  : landing request present
//   req_ready  : queue can accept (request transfers when valid && ready)
//   code[3:0]  : command: A=1010, B=1011, wait=1101, idle=0000
//   en         : one-cycle qualifier for code
//   occ_a/b    : runway A / B occupied
//   q_count    : entries currently queued
//   landed_cnt : landings dispatched to A or B (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module runway_scheduler #(
    parameter int OCC_CYCLES = 16,  // legal range 2..255
    parameter int DEPTH      = 4    // power of 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    output logic [3:0]               code,
    output logic                     en,
    output logic                     occ_a,
    output logic                     occ_b,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [7:0]               landed_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [3:0] CODE_A    = 4'b1010;
    localparam logic [3:0] CODE_B    = 4'b1011;
    localparam logic [3:0] CODE_WAIT = 4'b1101;
    localparam logic [3:0] CODE_IDLE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,      // queue empty
        DISPATCH,  // head present, no wait issued for it yet
        HOLD       // head present, wait already issued
    } state_t;

    state_t        state;
    logic [7:0]    timer_a;
    logic [7:0]    timer_b;

    logic          push;
    logic          go_a;
    logic          go_b;
    logic          pop;
    logic [CW-1:0] q_next;
    logic [7:0]    timer_a_next;
    logic [7:0]    timer_b_next;

    // Requests carry no payload, so the FIFO reduces to its occupancy count:
    // order is implicit and only the number of waiting aircraft matters.
    assign req_ready = (q_count < CW'(DEPTH));
    assign push      = req_valid && req_ready;

    // A head exists in any non-IDLE state. Eligibility uses the registered
    // occ flags, so a runway is reusable the cycle after occ drops.
    assign go_a = (state != IDLE) && !occ_a;
    assign go_b = (state != IDLE) && occ_a && !occ_b;
    assign pop  = go_a || go_b;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        q_next = q_count;
        if (push && !pop)
            q_next = q_count + 1'b1;
        else if (!push && pop)
            q_next = q_count - 1'b1;

        timer_a_next = (timer_a != 8'd0) ? timer_a - 8'd1 : 8'd0;
        timer_b_next = (timer_b != 8'd0) ? timer_b - 8'd1 : 8'd0;
        if (go_a)
            timer_a_next = 8'(OCC_CYCLES);
        if (go_b)
            timer_b_next = 8'(OCC_CYCLES);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            q_count    <= '0;
            timer_a    <= 8'd0;
            timer_b    <= 8'd0;
            occ_a      <= 1'b0;
            occ_b      <= 1'b0;
            code       <= CODE_IDLE;
            en         <= 1'b0;
            landed_cnt <= 8'd0;
        end else begin
            q_count <= q_next;
            timer_a <= timer_a_next;
            timer_b <= timer_b_next;
            occ_a   <= (timer_a_next != 8'd0);
            occ_b   <= (timer_b_next != 8'd0);

            code <= CODE_IDLE;
            en   <= 1'b0;
            if (pop) begin
                code       <= go_a ? CODE_A : CODE_B;
                en         <= 1'b1;
                landed_cnt <= landed_cnt + 8'd1;
            end else if (state == DISPATCH) begin
                code <= CODE_WAIT;
                en   <= 1'b1;
            end

            case (state)
                IDLE:     if (push) state <= DISPATCH;
                DISPATCH: begin
                    if (pop)
                        state <= (q_next != '0) ? DISPATCH : IDLE;
                    else
                        state <= HOLD;
                end
                HOLD:     if (pop) state <= (q_next != '0) ? DISPATCH : IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_runway_scheduler.sv
// -----------------------------------------------------------------------------
// tb_runway_scheduler
//
// Randomised and directed stimulus for runway_scheduler. The reference model
// tracks a queue length and, per runway, the first edge at which that runway
// may be used again; commands follow from those with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_runway_scheduler;

    localparam int OCC   = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] code;
    logic       en;
    logic       occ_a;
    logic       occ_b;
    logic [2:0] q_count;
    logic [7:0] landed_cnt;

    runway_scheduler #(.OCC_CYCLES(OCC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .code       (code),
        .en         (en),
        .occ_a      (occ_a),
        .occ_b      (occ_b),
        .q_count    (q_count),
        .landed_cnt (landed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_q;        // aircraft waiting
    int         m_t;        // edge index since last reset
    int         free_a;     // first edge at which runway A may take a landing
    int         free_b;
    bit         waited;     // wait already announced for current head
    logic [7:0] m_landed;
    int         m_disp;     // dispatches since last reset (unwrapped)

    logic [3:0] obs_code[$];
    int         obs_t[$];

    task automatic model_reset();
        m_q = 0; m_t = 0; free_a = 0; free_b = 0;
        waited = 0; m_landed = 8'd0; m_disp = 0;
    endtask

    // One clock: drive request, advance model across the edge, compare.
    task automatic cycle(input bit v);
        bit         acc, pop, x_en;
        logic [3:0] x_code;
        req_valid = v;
        @(posedge clk);
        acc = v && (m_q < DEPTH);
        pop = 0; x_en = 0; x_code = 4'b0000;
        if (m_q > 0) begin
            if (m_t >= free_a) begin
                pop = 1; x_code = 4'b1010; free_a = m_t + OCC + 1;
            end else if (m_t >= free_b) begin
                pop = 1; x_code = 4'b1011; free_b = m_t + OCC + 1;
            end else if (!waited) begin
                x_code = 4'b1101; waited = 1;
            end
            x_en = pop || (x_code == 4'b1101);
        end
        if (pop) begin
            waited = 0; m_landed = m_landed + 8'd1; m_disp++;
        end
        m_q = m_q + int'(acc) - int'(pop);
        #1;
        check("code",       code,       x_code);
        check("en",         en,         x_en);
        // occupied for OCC edges starting with the dispatch edge
        check("occ_a",      occ_a,      (m_t + 2 <= free_a));
        check("occ_b",      occ_b,      (m_t + 2 <= free_b));
        check("q_count",    q_count,    m_q);
        check("landed_cnt", landed_cnt, m_landed);
        check("req_ready",  req_ready,  (m_q < DEPTH));
        if (en) begin
            obs_code.push_back(code);
            obs_t.push_back(m_t);
        end
        m_t++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_code"},  code,       4'b0000);
        check({tag, "_en"},    en,         1'b0);
        check({tag, "_occ_a"}, occ_a,      1'b0);
        check({tag, "_occ_b"}, occ_b,      1'b0);
        check({tag, "_q"},     q_count,    3'd0);
        check({tag, "_land"},  landed_cnt, 8'd0);
        check({tag, "_ready"}, req_ready,  1'b1);
    endtask

    // Assert reset between edges, verify asynchronous effect, release mid-cycle.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int occ_len, land0, budget, dens;
        bit saw_full;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: A command one edge after acceptance, 16 cycles busy.
        cycle(1'b1);
        cycle(1'b0);
        check("single_code", code, 4'b1010);
        check("single_en",   en,   1'b1);
        check("single_land", landed_cnt, 8'd1);
        occ_len = int'(occ_a);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0);
            occ_len += int'(occ_a);
        end
        check("single_occ_len", occ_len, OCC);

        // Three back-to-back requests: A, B, one wait, then A once free.
        obs_code.delete(); obs_t.delete();
        land0 = int'(landed_cnt);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0);
        check("three_en_count", obs_code.size(), 4);
        if (obs_code.size() == 4) begin
            check("three_c0", obs_code[0], 4'b1010);
            check("three_c1", obs_code[1], 4'b1011);
            check("three_c2", obs_code[2], 4'b1101);
            check("three_c3", obs_code[3], 4'b1010);
            check("three_gap", obs_t[3] - obs_t[0], OCC + 1);
        end
        check("three_land", int'(landed_cnt) - land0, 3);

        // Fill: both busy, queue must saturate and hold off further requests.
        saw_full = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(1'b1);
            if (q_count == 3'd4 && !req_ready) saw_full = 1;
        end
        check("fill_saw_full", saw_full, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b0);

        // Randomised traffic with varying density.
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(100);
            for (int i = 0; i < 100; i++) cycle($urandom_range(99) < dens);
        end

        // Reset mid-HOLD with three queued.
        async_reset("rst_a");
        for (int i = 0; i < 5; i++) cycle(1'b1);
        check("hold_q3", q_count, 3'd3);
        check("hold_occ", {occ_a, occ_b}, 2'b11);
        async_reset("rst_hold");
        cycle(1'b1);
        cycle(1'b0);
        check("post_rst_code", code, 4'b1010);
        check("post_rst_en",   en,   1'b1);

        // Wrap of landed_cnt after 256 dispatches.
        async_reset("rst_b");
        budget = 0;
        while (m_disp < 256 && budget < 5000) begin
            cycle(1'b1);
            budget++;
        end
        check("wrap_budget", (m_disp >= 256), 1'b1);
        check("wrap_land", landed_cnt, 8'd0);

        req_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
